// File: rtl/shreg_pkg.sv
// Shared definitions for the shift-register feed sequencer: state encoding,
// delivery mode constants and default widths.
package shreg_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_W  = 4;

  localparam logic MODE_SERIAL   = 1'b0;
  localparam logic MODE_PARALLEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shreg_feed_cnt.sv
// Loadable down-counter with enable; holds at zero. Tracks which bit or chunk
// of the current word is on the register inputs.
module shreg_feed_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement, and the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/shreg_feed_ctrl.sv
// Feeds DATA_W-bit words into a REG_W-bit shift register, either serially
// (Sh/SI, MSB first) or as parallel chunks (L/D, MSB chunk first).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a word, in_ready=1
// ST_SHIFT | presenting bits on SI with Sh (hold pauses)
// ST_LOAD  | presenting chunks on D with L (hold pauses)
// ST_DONE  | one-cycle done pulse, then back to idle
//
// The counter holds the index of the bit/chunk currently on the outputs; the
// accept edge already presents the first item so it shows one cycle later.
module shreg_feed_ctrl
  import shreg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              hold,
  output logic              in_ready,
  output logic              L,
  output logic              Sh,
  output logic              SI,
  output logic [REG_W-1:0]  D,
  output logic              busy,
  output logic              done
);

  localparam int N_SER = DATA_W;
  localparam int N_PAR = DATA_W / REG_W;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] SER_LAST = CNT_W'(N_SER - 1);
  localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(N_PAR - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                l_q, l_d;
  logic                sh_q, sh_d;
  logic                si_q, si_d;
  logic [REG_W-1:0]    d_q, d_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept;
  logic                active;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_zero;
  logic [CNT_W-1:0]    cnt_dec;
  logic [CNT_W-1:0]    cnt_ld_val;
  logic                ser_bit;
  logic [REG_W-1:0]    par_chunk;

  assign in_ready   = (state_q == ST_IDLE);
  assign accept     = in_ready && in_valid;
  assign active     = (state_q == ST_SHIFT) || (state_q == ST_LOAD);
  assign cnt_ld_val = (in_mode == MODE_PARALLEL) ? PAR_LAST : SER_LAST;
  assign cnt_dec    = cnt - 1'b1;

  shreg_feed_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (cnt_ld_val),
    .en       (active && !hold),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Select the next pending bit/chunk of the latched word (index cnt-1).
  always_comb begin
    ser_bit   = 1'b0;
    par_chunk = '0;
    for (int i = 0; i < N_SER; i++) begin
      if (int'(cnt_dec) == i) ser_bit = word_q[i];
    end
    for (int j = 0; j < N_PAR; j++) begin
      if (int'(cnt_dec) == j) par_chunk = word_q[j*REG_W +: REG_W];
    end
  end

  // State, data latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      l_q     <= 1'b0;
      sh_q    <= 1'b0;
      si_q    <= 1'b0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      l_q     <= l_d;
      sh_q    <= sh_d;
      si_q    <= si_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = (in_mode == MODE_PARALLEL) ? ST_LOAD : ST_SHIFT;
      ST_SHIFT,
      ST_LOAD:  if (!hold && cnt_zero) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output register inputs: strobes default low, SI/D keep their last value.
  always_comb begin
    word_d = word_q;
    l_d    = 1'b0;
    sh_d   = 1'b0;
    si_d   = si_q;
    d_d    = d_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d = in_data;
          busy_d = 1'b1;
          if (in_mode == MODE_SERIAL) begin
            sh_d = 1'b1;
            si_d = in_data[DATA_W-1];
          end else begin
            l_d  = 1'b1;
            si_d = 1'b0;
            d_d  = in_data[DATA_W-1 -: REG_W];
          end
        end
      end
      ST_SHIFT,
      ST_LOAD: begin
        busy_d = 1'b1;
        if (!hold) begin
          if (cnt_zero) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else if (state_q == ST_SHIFT) begin
            sh_d = 1'b1;
            si_d = ser_bit;
          end else begin
            l_d = 1'b1;
            d_d = par_chunk;
          end
        end
      end
      default: ;
    endcase
  end

  assign L    = l_q;
  assign Sh   = sh_q;
  assign SI   = si_q;
  assign D    = d_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shreg_feed_ctrl.sv
// Testbench for shreg_feed_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based delivery model.
module tb_shreg_feed_ctrl;

  localparam int DATA_W = 8;
  localparam int REG_W  = 4;
  localparam int N_PAR  = DATA_W / REG_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_mode;
  logic              hold;
  logic              in_ready;
  logic              L;
  logic              Sh;
  logic              SI;
  logic [REG_W-1:0]  D;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  // reference model: phase 0 idle, 1 delivering, 2 done pulse
  int               m_phase;
  logic             m_par;
  logic [REG_W-1:0] m_items[$];
  logic             e_L, e_Sh, e_SI, e_busy, e_done;
  logic [REG_W-1:0] e_D;

  shreg_feed_ctrl #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .hold     (hold),
    .in_ready (in_ready),
    .L        (L),
    .Sh       (Sh),
    .SI       (SI),
    .D        (D),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_phase = 0;
    m_par   = 1'b0;
    m_items.delete();
    e_L = 0; e_Sh = 0; e_SI = 0; e_D = '0; e_busy = 0; e_done = 0;
  endfunction

  function automatic void present_next();
    logic [REG_W-1:0] it;
    it = m_items.pop_front();
    if (m_par) begin
      e_L = 1'b1;
      e_D = it;
    end else begin
      e_Sh = 1'b1;
      e_SI = it[0];
    end
  endfunction

  function automatic void model_step();
    e_L = 0; e_Sh = 0; e_done = 0;
    case (m_phase)
      0: begin
        if (in_valid) begin
          m_par = in_mode;
          m_items.delete();
          if (in_mode) begin
            for (int j = N_PAR - 1; j >= 0; j--) m_items.push_back(in_data[j*REG_W +: REG_W]);
            e_SI = 1'b0;
          end else begin
            for (int i = DATA_W - 1; i >= 0; i--) m_items.push_back({{(REG_W-1){1'b0}}, in_data[i]});
          end
          present_next();
          m_phase = 1;
          e_busy  = 1'b1;
        end else begin
          e_busy = 1'b0;
        end
      end
      1: begin
        if (!hold) begin
          if (m_items.size() > 0) present_next();
          else begin
            m_phase = 2;
            e_busy  = 1'b0;
            e_done  = 1'b1;
          end
        end
      end
      default: begin
        m_phase = 0;
        e_busy  = 1'b0;
      end
    endcase
  endfunction

  function automatic logic [9:0] exp_vec();
    return {e_L, e_Sh, e_SI, e_D, e_busy, e_done, (m_phase == 0)};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {L, Sh, SI, D, busy, done, in_ready};
  endfunction

  // One clock: model follows the edge, outputs are then sampled at negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; in_data = '0; in_mode = 0; hold = 0;
    tick();
    tick();
    checks++;
    if ({L, Sh, SI, D, busy, done} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", {L, Sh, SI, D, busy, done}, 9'b0);
    end
    rst_n = 1;
    tick();
    checks++;
    if (obs_vec() !== 10'b0000000001) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs_vec(), 10'b0000000001);
    end
  endtask

  task automatic test_serial();
    logic [7:0] w;
    w = 8'hB6;
    in_valid = 1; in_data = w; in_mode = 0; hold = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      if (c <= 8) begin
        checks++;
        if ({Sh, SI, L, in_ready, done} !== {1'b1, w[8-c], 1'b0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL serial_bit%0d: got Sh/SI/L/rdy/done=%b want %b", c,
                   {Sh, SI, L, in_ready, done}, {1'b1, w[8-c], 3'b000});
        end
      end else if (c == 9) begin
        checks++;
        if ({done, busy, Sh, L, in_ready} !== 5'b10000) begin
          errors++;
          $display("FAIL serial_done: got done/busy/Sh/L/rdy=%b want 10000", {done, busy, Sh, L, in_ready});
        end
      end else begin
        checks++;
        if ({in_ready, done, busy} !== 3'b100) begin
          errors++;
          $display("FAIL serial_idle: got rdy/done/busy=%b want 100", {in_ready, done, busy});
        end
      end
    end
  endtask

  task automatic test_parallel();
    logic [3:0] exp_d;
    in_valid = 1; in_data = 8'hA6; in_mode = 1; hold = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      if (c <= 2) begin
        exp_d = (c == 1) ? 4'hA : 4'h6;
        checks++;
        if ({L, Sh, SI, D, busy} !== {1'b1, 1'b0, 1'b0, exp_d, 1'b1}) begin
          errors++;
          $display("FAIL parallel_chunk%0d: got L/Sh/SI/D/busy=%b want %b", c,
                   {L, Sh, SI, D, busy}, {3'b100, exp_d, 1'b1});
        end
      end else if (c == 3) begin
        checks++;
        if ({done, L, Sh, busy} !== 4'b1000) begin
          errors++;
          $display("FAIL parallel_done: got done/L/Sh/busy=%b want 1000", {done, L, Sh, busy});
        end
      end else begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL parallel_idle: got rdy=%b want 1", in_ready);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] seq;
    int pulses, done_cyc;
    seq = '0; pulses = 0; done_cyc = 0;
    in_valid = 1; in_data = 8'hB6; in_mode = 0; hold = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      if (Sh) begin
        seq = {seq[6:0], SI};
        pulses++;
      end
      if (done && done_cyc == 0) done_cyc = c;
      if (c == 4 || c == 5) begin
        checks++;
        if ({Sh, L, SI, busy} !== 4'b0011) begin
          errors++;
          $display("FAIL hold_cycle%0d: got Sh/L/SI/busy=%b want 0011", c, {Sh, L, SI, busy});
        end
      end
      hold = (c == 3 || c == 4);
    end
    checks++;
    if (seq !== 8'hB6) begin
      errors++;
      $display("FAIL hold_sequence: got %h want b6", seq);
    end
    checks++;
    if (pulses != 8) begin
      errors++;
      $display("FAIL hold_pulses: got %0d want 8", pulses);
    end
    checks++;
    if (done_cyc != 11) begin
      errors++;
      $display("FAIL hold_done_cycle: got %0d want 11", done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'h3C;
    in_valid = 1; in_data = w; in_mode = 0; hold = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) begin
        in_data = 8'hC3;
        in_mode = 1;
      end
      if (c <= 8) begin
        checks++;
        if ({Sh, SI, L} !== {1'b1, w[8-c], 1'b0}) begin
          errors++;
          $display("FAIL b2b_bit%0d: got Sh/SI/L=%b want %b", c, {Sh, SI, L}, {1'b1, w[8-c], 1'b0});
        end
      end else if (c == 9 || c == 10) begin
        checks++;
        if ({L, Sh, done, in_ready} !== {2'b00, (c == 9), (c == 10)}) begin
          errors++;
          $display("FAIL b2b_gap%0d: got L/Sh/done/rdy=%b want %b", c,
                   {L, Sh, done, in_ready}, {2'b00, (c == 9), (c == 10)});
        end
      end else if (c == 11 || c == 12) begin
        checks++;
        if ({L, Sh, D} !== {2'b10, (c == 11) ? 4'hC : 4'h3}) begin
          errors++;
          $display("FAIL b2b_chunk%0d: got L/Sh/D=%b want %b", c,
                   {L, Sh, D}, {2'b10, (c == 11) ? 4'hC : 4'h3});
        end
        if (c == 11) in_valid = 0;
      end else if (c == 13) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done: got %b want 1", done);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq;
    int done_cyc;
    in_valid = 1; in_data = 8'hFF; in_mode = 0; hold = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) in_valid = 0;
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if ({L, Sh, SI, D, busy, done, in_ready} !== 10'b0000000001) begin
      errors++;
      $display("FAIL midreset_async: got %b want 0000000001", {L, Sh, SI, D, busy, done, in_ready});
    end
    tick();
    rst_n = 1;
    tick();
    checks++;
    if ({done, busy, Sh} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_nodone: got done/busy/Sh=%b want 000", {done, busy, Sh});
    end
    seq = '0; done_cyc = 0;
    in_valid = 1; in_data = 8'h81; in_mode = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) in_valid = 0;
      if (Sh) seq = {seq[6:0], SI};
      if (done && done_cyc == 0) done_cyc = c;
    end
    checks++;
    if (seq !== 8'h81) begin
      errors++;
      $display("FAIL midreset_next_word: got %h want 81", seq);
    end
    checks++;
    if (done_cyc != 9) begin
      errors++;
      $display("FAIL midreset_done_cycle: got %0d want 9", done_cyc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = DATA_W'($urandom);
      in_mode  = 1'($urandom_range(0, 1));
      hold     = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d: got L/Sh/SI/D/busy/done/rdy=%b want %b", n, obs_vec(), exp_vec());
      end
      checks++;
      if (L && Sh) begin
        errors++;
        $display("FAIL random_strobe_overlap%0d: got L=%b Sh=%b want not both", n, L, Sh);
      end
    end
    in_valid = 0; hold = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serial();
    test_parallel();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
